// File: rtl/alu_mc_unit.sv
// rtl/alu_mc_unit.sv - ALU with single-cycle ops and an iterative shift-add multiply
// Captures one request at a time, holds the result in DONE until the consumer takes it.
module alu_mc_unit #(
   parameter int WIDTH  = 32,
   parameter bit MUL_EN = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       alu_op,
   input  logic [5:0]       func,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [3:0]       alu_func,
   output logic             zero,
   output logic             err
);

   localparam logic [1:0] S_IDLE = 2'b00;
   localparam logic [1:0] S_EXEC = 2'b01;
   localparam logic [1:0] S_DONE = 2'b10;

   localparam logic [3:0] F_AND = 4'b0000;
   localparam logic [3:0] F_OR  = 4'b0001;
   localparam logic [3:0] F_ADD = 4'b0010;
   localparam logic [3:0] F_SUB = 4'b0110;
   localparam logic [3:0] F_SLT = 4'b0111;
   localparam logic [3:0] F_MUL = 4'b1000;
   localparam logic [3:0] F_NOR = 4'b1100;
   localparam logic [3:0] F_ERR = 4'b1111;

   localparam int            CW       = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [3:0]       func_q, func_d;
   logic             err_q, err_d;
   logic             zero_q, zero_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   logic [3:0]       dec_func;
   logic             dec_err;
   logic [WIDTH-1:0] alu_res;
   logic [WIDTH-1:0] acc_step;
   logic             accept;

   always_comb begin
      dec_func = F_ERR;
      dec_err  = 1'b1;
      case (alu_op)
         2'b00: begin dec_func = F_ADD; dec_err = 1'b0; end
         2'b01: begin dec_func = F_SUB; dec_err = 1'b0; end
         2'b10: begin
            case (func)
               6'b100100: begin dec_func = F_AND; dec_err = 1'b0; end
               6'b100101: begin dec_func = F_OR;  dec_err = 1'b0; end
               6'b100000: begin dec_func = F_ADD; dec_err = 1'b0; end
               6'b100010: begin dec_func = F_SUB; dec_err = 1'b0; end
               6'b101010: begin dec_func = F_SLT; dec_err = 1'b0; end
               6'b100111: begin dec_func = F_NOR; dec_err = 1'b0; end
               6'b011000: begin
                  if (MUL_EN) begin
                     dec_func = F_MUL;
                     dec_err  = 1'b0;
                  end
               end
               default: ;
            endcase
         end
         default: ;
      endcase
   end

   // MUL and illegal codes both yield zero here; MUL takes the EXEC path instead
   always_comb begin
      alu_res = '0;
      case (dec_func)
         F_AND:   alu_res = op_a & op_b;
         F_OR:    alu_res = op_a | op_b;
         F_ADD:   alu_res = op_a + op_b;
         F_SUB:   alu_res = op_a - op_b;
         F_SLT:   alu_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
         F_NOR:   alu_res = ~(op_a | op_b);
         default: alu_res = '0;
      endcase
   end

   assign accept   = in_valid && in_ready;
   assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

   always_comb begin
      state_d  = state_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      result_d = result_q;
      func_d   = func_q;
      err_d    = err_q;
      zero_d   = zero_q;
      cnt_d    = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               func_d = dec_func;
               err_d  = dec_err;
               cnt_d  = '0;
               if (dec_func == F_MUL) begin
                  state_d  = S_EXEC;
                  mcand_d  = op_a;
                  mplier_d = op_b;
                  acc_d    = '0;
               end else begin
                  state_d  = S_DONE;
                  result_d = alu_res;
                  zero_d   = (alu_res == '0);
               end
            end
         end
         S_EXEC: begin
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
            // The last iteration lands straight in the result register
            if (cnt_q == CNT_LAST) begin
               state_d  = S_DONE;
               result_d = acc_step;
               zero_d   = (acc_step == '0);
            end
         end
         S_DONE: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         result_q <= '0;
         func_q   <= 4'b0000;
         err_q    <= 1'b0;
         zero_q   <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         result_q <= result_d;
         func_q   <= func_d;
         err_q    <= err_d;
         zero_q   <= zero_d;
         cnt_q    <= cnt_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign result    = result_q;
   assign alu_func  = func_q;
   assign zero      = zero_q;
   assign err       = err_q;

endmodule

// File: tb/tb_alu_mc_unit.sv
// tb/tb_alu_mc_unit.sv - directed table, reset corner cases and random ops against a reference model
module tb_alu_mc_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  alu_op;
   logic [5:0]  func;
   logic [31:0] op_a, op_b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic [3:0]  alu_func;
   logic        zero;
   logic        err;

   int tests = 0;
   int fails = 0;

   alu_mc_unit #(.WIDTH(32), .MUL_EN(1'b1)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .alu_op    (alu_op),
      .func      (func),
      .op_a      (op_a),
      .op_b      (op_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .alu_func  (alu_func),
      .zero      (zero),
      .err       (err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  op;
      logic [5:0]  fn;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic [3:0]  af;
      logic        er;
      int          lat;
      int          stall;
   } vec_t;

   typedef struct {
      logic [31:0] res;
      logic [3:0]  af;
      logic        er;
      int          lat;
   } exp_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: plain arithmetic on the architectural rules
   function automatic exp_t model(input logic [1:0] op, input logic [5:0] fn,
                                  input logic [31:0] a, input logic [31:0] b);
      exp_t        e;
      logic [63:0] p;
      e.res = 32'd0; e.af = 4'hF; e.er = 1'b1; e.lat = 1;
      if (op == 2'd0) begin
         e.res = a + b; e.af = 4'b0010; e.er = 1'b0;
      end else if (op == 2'd1) begin
         e.res = a - b; e.af = 4'b0110; e.er = 1'b0;
      end else if (op == 2'd2) begin
         case (fn)
            6'b100100: begin e.res = a & b;    e.af = 4'b0000; e.er = 1'b0; end
            6'b100101: begin e.res = a | b;    e.af = 4'b0001; e.er = 1'b0; end
            6'b100000: begin e.res = a + b;    e.af = 4'b0010; e.er = 1'b0; end
            6'b100010: begin e.res = a - b;    e.af = 4'b0110; e.er = 1'b0; end
            6'b100111: begin e.res = ~(a | b); e.af = 4'b1100; e.er = 1'b0; end
            6'b101010: begin
               e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
               e.af = 4'b0111; e.er = 1'b0;
            end
            6'b011000: begin
               p = {32'd0, a} * {32'd0, b};
               e.res = p[31:0]; e.af = 4'b1000; e.er = 1'b0; e.lat = 33;
            end
            default: ;
         endcase
      end
      return e;
   endfunction

   task automatic run_op(input string name, input logic [1:0] op, input logic [5:0] fn,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] e_res, input logic [3:0] e_af, input logic e_err,
                         input int e_lat, input int stall);
      int n;
      int busy_rdy;
      alu_op = op; func = fn; op_a = a; op_b = b; in_valid = 1'b1; out_ready = 1'b0;
      check({name, " ready_before"}, 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      n = 1;
      busy_rdy = 0;
      while (!out_valid && n < 100) begin
         if (in_ready) busy_rdy++;
         in_valid = 1'($urandom_range(0, 1));
         alu_op = 2'($urandom_range(0, 3));
         func = 6'($urandom);
         op_a = $urandom;
         op_b = $urandom;
         @(posedge clk); #1;
         n++;
      end
      in_valid = 1'b0;
      check({name, " latency"}, 64'(n), 64'(e_lat));
      check({name, " busy_in_ready"}, 64'(busy_rdy), 64'd0);
      check({name, " result"}, 64'(result), 64'(e_res));
      check({name, " alu_func"}, 64'(alu_func), 64'(e_af));
      check({name, " err"}, 64'(err), 64'(e_err));
      check({name, " zero"}, 64'(zero), 64'(e_res == 32'd0));
      check({name, " done_in_ready"}, 64'(in_ready), 64'd0);
      for (int s = 0; s < stall; s++) begin
         op_a = $urandom;
         @(posedge clk); #1;
         check({name, " stall_hold"}, {31'd0, out_valid, in_ready, result}, {31'd0, 1'b1, 1'b0, e_res});
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({name, " after_handoff"}, {62'd0, out_valid, in_ready}, {62'd0, 1'b0, 1'b1});
   endtask

   vec_t        vecs[15];
   logic [5:0]  legal[7];
   exp_t        e;
   logic [1:0]  r_op;
   logic [5:0]  r_fn;
   logic [31:0] r_a, r_b;
   int          seen;

   initial begin
      vecs[0]  = '{2'd2, 6'b100000, 32'hFFFFFFFF, 32'd1,        32'd0,        4'b0010, 1'b0, 1,  0};
      vecs[1]  = '{2'd2, 6'b101010, 32'hFFFFFFFE, 32'd3,        32'd1,        4'b0111, 1'b0, 1,  0};
      vecs[2]  = '{2'd2, 6'b101010, 32'd3,        32'hFFFFFFFE, 32'd0,        4'b0111, 1'b0, 1,  0};
      vecs[3]  = '{2'd2, 6'b011000, 32'h00010003, 32'h00020005, 32'h000B000F, 4'b1000, 1'b0, 33, 0};
      vecs[4]  = '{2'd2, 6'b000000, 32'h12345678, 32'h9ABCDEF0, 32'd0,        4'b1111, 1'b1, 1,  0};
      vecs[5]  = '{2'd3, 6'b100000, 32'h00000005, 32'h00000006, 32'd0,        4'b1111, 1'b1, 1,  0};
      vecs[6]  = '{2'd2, 6'b100100, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 4'b0000, 1'b0, 1,  5};
      vecs[7]  = '{2'd0, 6'b000000, 32'd7,        32'd5,        32'd12,       4'b0010, 1'b0, 1,  0};
      vecs[8]  = '{2'd1, 6'b111111, 32'd0,        32'd1,        32'hFFFFFFFF, 4'b0110, 1'b0, 1,  1};
      vecs[9]  = '{2'd2, 6'b100111, 32'd0,        32'd0,        32'hFFFFFFFF, 4'b1100, 1'b0, 1,  0};
      vecs[10] = '{2'd2, 6'b100101, 32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 4'b0001, 1'b0, 1,  0};
      vecs[11] = '{2'd2, 6'b100010, 32'd5,        32'd7,        32'hFFFFFFFE, 4'b0110, 1'b0, 1,  0};
      vecs[12] = '{2'd2, 6'b011000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,        4'b1000, 1'b0, 33, 2};
      vecs[13] = '{2'd2, 6'b011000, 32'd0,        32'h87654321, 32'd0,        4'b1000, 1'b0, 33, 0};
      vecs[14] = '{2'd2, 6'b101010, 32'h80000000, 32'h7FFFFFFF, 32'd1,        4'b0111, 1'b0, 1,  0};
      legal = '{6'b100100, 6'b100101, 6'b100000, 6'b100010, 6'b101010, 6'b100111, 6'b011000};

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      alu_op = 2'd0; func = 6'd0; op_a = 32'd0; op_b = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_state", {in_ready, out_valid, result, alu_func, zero, err},
            {1'b1, 1'b0, 32'd0, 4'b0000, 1'b0, 1'b0});
      rst_n = 1'b1;

      // First request is presented on the first edge after release
      for (int i = 0; i < 15; i++) begin
         run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].fn, vecs[i].a, vecs[i].b,
                vecs[i].res, vecs[i].af, vecs[i].er, vecs[i].lat, vecs[i].stall);
      end

      // Reset in the middle of a multiply
      alu_op = 2'd2; func = 6'b011000; op_a = 32'h1234; op_b = 32'h5678; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (10) begin @(posedge clk); #1; end
      check("exec10_busy", {62'd0, out_valid, in_ready}, {62'd0, 1'b0, 1'b0});
      rst_n = 1'b0;
      #1;
      check("exec_reset_vals", {in_ready, out_valid, result, alu_func, zero, err},
            {1'b1, 1'b0, 32'd0, 4'b0000, 1'b0, 1'b0});
      @(posedge clk); #1;
      rst_n = 1'b1;
      seen = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (out_valid) seen++;
      end
      check("exec_reset_no_valid", 64'(seen), 64'd0);
      run_op("add_after_reset", 2'd0, 6'd0, 32'd2, 32'd3, 32'd5, 4'b0010, 1'b0, 1, 0);

      // Reset while a result is waiting in DONE
      alu_op = 2'd0; op_a = 32'd9; op_b = 32'd1; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("done_pre_reset", {31'd0, out_valid, result}, {31'd0, 1'b1, 32'd10});
      rst_n = 1'b0;
      #1;
      check("done_reset_vals", {in_ready, out_valid, result, alu_func}, {1'b1, 1'b0, 32'd0, 4'b0000});
      @(posedge clk); #1;
      rst_n = 1'b1;
      seen = 0;
      repeat (5) begin
         @(posedge clk); #1;
         if (out_valid) seen++;
      end
      check("done_reset_no_valid", 64'(seen), 64'd0);

      for (int k = 0; k < 40; k++) begin
         r_op = 2'($urandom_range(0, 3));
         r_fn = ($urandom_range(0, 4) != 0) ? legal[$urandom_range(0, 6)] : 6'($urandom);
         r_a  = ($urandom_range(0, 5) == 0) ? 32'hFFFFFFFF : $urandom;
         r_b  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
         e = model(r_op, r_fn, r_a, r_b);
         run_op($sformatf("rnd%0d", k), r_op, r_fn, r_a, r_b, e.res, e.af, e.er, e.lat,
                $urandom_range(0, 2));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
